// File: rtl/alu_issue_sched_pkg.sv
// Shared integer-pipeline types: operation codes, exceptions and the ALU
// request/response records used by the issue schedulers.
package cpu_defs;

    localparam int ALU_TAG_W = 6;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDU = 4'd2,
        OP_SUB  = 4'd3,
        OP_SUBU = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } oper_t;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;
    typedef logic [ALU_TAG_W-1:0] alu_tag_t;

    localparam logic [4:0] EXCCODE_NONE = 5'd0;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    typedef struct packed {
        logic       valid;
        logic [4:0] exc_code;
    } exception_t;

    typedef struct packed {
        oper_t    op;
        virt_t    pc;
        uint32_t  instr;
        uint32_t  reg1;
        uint32_t  reg2;
        alu_tag_t tag;
    } alu_req_t;

    typedef struct packed {
        alu_tag_t   tag;
        uint32_t    result;
        exception_t ex;
    } alu_resp_t;

endpackage

// File: rtl/alu_issue_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner only when the grant is actually taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx_s;
    logic [PW-1:0] win_s;
    logic          found_s;

    // N is a power of two, so pointer arithmetic wraps naturally
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        win_s   = ptr_q;
        idx_s   = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx_s = ptr_q + PW'(k);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
                win_s        = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // next pointer
    always_comb begin
        if (advance && found_s) begin
            ptr_d = win_s + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Shares one integer ALU among NREQ reservation stations: round-robin grant,
// one-cycle issue register, and a 2-entry result FIFO feeding the CDB.
module alu_issue_sched
    import cpu_defs::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  oper_t [NREQ-1:0]           req_op,
    input  logic [NREQ-1:0][31:0]      req_pc,
    input  logic [NREQ-1:0][31:0]      req_instr,
    input  logic [NREQ-1:0][31:0]      req_reg1,
    input  logic [NREQ-1:0][31:0]      req_reg2,
    input  logic [NREQ-1:0][TAG_W-1:0] req_tag,
    output oper_t                      alu_op,
    output logic [31:0]                alu_pc,
    output logic [31:0]                alu_instr,
    output logic [31:0]                alu_reg1,
    output logic [31:0]                alu_reg2,
    input  logic [31:0]                alu_result,
    input  exception_t                 alu_ex,
    output logic                       cdb_valid,
    input  logic                       cdb_ready,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [31:0]                cdb_result,
    output exception_t                 cdb_ex
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        oper_t            op;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      reg1;
        logic [31:0]      reg2;
        logic [TAG_W-1:0] tag;
    } iss_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      result;
        exception_t       ex;
    } ent_t;

    logic            run_q;
    logic            iss_valid_q, iss_valid_d;
    iss_t            iss_q, iss_d;
    ent_t            fifo_q [2];
    ent_t            fifo_d [2];
    logic [1:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;

    logic [1:0]      occ_s;
    logic            pop_s;
    logic            push_s;
    logic            can_issue_s;
    logic [NREQ-1:0] arb_grant_s;
    logic [IW-1:0]   sel_s;

    // run_q keeps grants off while rst_n is low, even with requesters valid
    assign occ_s       = cnt_q + {1'b0, iss_valid_q};
    assign pop_s       = cdb_valid & cdb_ready;
    assign push_s      = iss_valid_q;
    assign can_issue_s = run_q & ~flush & ((occ_s < 2'd2) | pop_s);
    assign req_ready   = arb_grant_s & {NREQ{can_issue_s}};

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (can_issue_s),
        .grant   (arb_grant_s)
    );

    // one-hot grant to requester index
    always_comb begin
        sel_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_s = sel_s | (arb_grant_s[k] ? IW'(k) : '0);
        end
    end

    // issue register next state; data fields hold when nothing is granted
    always_comb begin
        iss_valid_d = |req_ready;
        iss_d       = iss_q;
        if (|req_ready) begin
            iss_d.op    = req_op[sel_s];
            iss_d.pc    = req_pc[sel_s];
            iss_d.instr = req_instr[sel_s];
            iss_d.reg1  = req_reg1[sel_s];
            iss_d.reg2  = req_reg2[sel_s];
            iss_d.tag   = req_tag[sel_s];
        end else begin
            iss_d = iss_q;
        end
    end

    // result FIFO next state; flush discards everything not yet popped
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (flush) begin
            cnt_d = 2'd0;
            wr_d  = 1'b0;
            rd_d  = 1'b0;
        end else begin
            if (push_s) begin
                fifo_d[wr_q] = '{tag: iss_q.tag, result: alu_result, ex: alu_ex};
                wr_d         = ~wr_q;
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = ~rd_q;
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // pipeline state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            cnt_q       <= 2'd0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            fifo_q      <= fifo_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end

    assign alu_op     = iss_q.op;
    assign alu_pc     = iss_q.pc;
    assign alu_instr  = iss_q.instr;
    assign alu_reg1   = iss_q.reg1;
    assign alu_reg2   = iss_q.reg2;

    assign cdb_valid  = (cnt_q != 2'd0);
    assign cdb_tag    = fifo_q[rd_q].tag;
    assign cdb_result = fifo_q[rd_q].result;
    assign cdb_ex     = fifo_q[rd_q].ex;

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Shares the single integer ALU datapath between NREQ reservation-station requesters in the out-of-order core.
- Round-robin arbitration selects one requester per cycle.
- Selected operands are registered into an issue register and evaluated by the combinational ALU one cycle later.
- The result, tag and exception are buffered in a 2-entry output FIFO that drives the common data bus (CDB) with a valid/ready handshake.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- TAG_W, 6, width of the ROB tag carried with each operation.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset.
- flush  in  1  synchronous pipeline flush (mispredict/exception).
- req_valid  in  NREQ  requester i has a ready op.
- req_ready  out  NREQ  grant; an op transfers when req_valid[i] & req_ready[i].
- req_op  in  NREQ x oper_t  operation code per requester.
- req_pc  in  NREQ x 32  pc per requester.
- req_instr  in  NREQ x 32  raw instruction per requester.
- req_reg1  in  NREQ x 32  operand 1 per requester.
- req_reg2  in  NREQ x 32  operand 2 per requester.
- req_tag  in  NREQ x TAG_W  ROB tag per requester.
- alu_op  out  oper_t  to ALU.
- alu_pc  out  32  to ALU.
- alu_instr  out  32  to ALU.
- alu_reg1  out  32  to ALU.
- alu_reg2  out  32  to ALU.
- alu_result  in  32  from ALU, same cycle.
- alu_ex  in  exception_t  from ALU, same cycle.
- cdb_valid  out  1  result available.
- cdb_ready  in  1  CDB accepts the result.
- cdb_tag  out  TAG_W  tag of the head entry.
- cdb_result  out  32  result of the head entry.
- cdb_ex  out  exception_t  exception of the head entry.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: req_ready=0, iss_valid=0, FIFO empty, cdb_valid=0, rr_ptr=0. alu_* and cdb_* data outputs are '0 (op = OP_NOP encoding 0). Asserting rst_n low mid-operation drops all in-flight ops immediately.
- Occupancy: occ = fifo_count + iss_valid, range 0..2. pop = cdb_valid & cdb_ready.
- can_issue = ~flush & ((occ < 2) | pop).
- Arbitration:
  - Scan from rr_ptr upward, wrapping modulo NREQ; grant the first i with req_valid[i].
  - req_ready is one-hot (or zero) and is gated by can_issue.
  - req_ready may depend combinationally on req_valid; req_valid must not depend on req_ready.
  - On a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds. flush does not change rr_ptr.
- Issue stage, cycle T (grant): at the end of T, the issue register latches op/pc/instr/reg1/reg2/tag and iss_valid <= 1. With no grant, iss_valid <= 0 and the data fields hold.
- Execute stage, cycle T+1:
  - alu_* outputs come directly from the issue register.
  - At the end of T+1, if iss_valid, push {tag, alu_result, alu_ex} into the FIFO.
  - The push is always accepted; the occupancy rule guarantees space.
- Output stage, cycle T+2:
  - The FIFO head drives cdb_* and cdb_valid = (fifo_count != 0).
  - Head data stays stable while cdb_valid & ~cdb_ready.
- Latency: grant to cdb_valid is exactly 2 cycles.
- Throughput: 1 op/cycle sustained while cdb_ready = 1.
- Simultaneous push and pop: fifo_count unchanged, and order is preserved. With count 1, the new entry becomes head on the next cycle.
- FIFO: 2 entries, read and write pointers wrap modulo 2, fifo_count in 0..2.
- Flush:
  - In the flush cycle, req_ready = 0.
  - At the end of that cycle: iss_valid <= 0, fifo_count <= 0, pointers <= 0.
  - A pop in the flush cycle still completes on the CDB.
- Exceptions: alu_ex is carried unmodified (valid and exc_code). The block never suppresses or reorders results with exceptions.

Decomposition:
- Package cpu_defs: typedef alu_tag_t (TAG_W bits); struct alu_req_t {oper_t op; virt_t pc; uint32_t instr, reg1, reg2; alu_tag_t tag;}; struct alu_resp_t {alu_tag_t tag; uint32_t result; exception_t ex;}.
- Sub-module rr_arbiter (parameter N): inputs req, advance; output one-hot grant. Holds rr_ptr internally. Reusable by other issue schedulers.
- The 2-entry FIFO stays inline.

Test Plan:
- Single op: req_valid=0001, op=OP_ADDU, reg1=5, reg2=7, tag=3 → req_ready=0001 at T; cdb_valid at T+2 with result=12, tag=3, cdb_ex.valid=0.
- Fairness: req_valid=1111 held, cdb_ready=1 → grants 0001,0010,0100,1000,0001 on consecutive cycles; CDB tags in the same order, one per cycle from T+2.
- Backpressure: cdb_ready=0, all requesters valid → exactly 2 grants, then req_ready=0000. Raise cdb_ready → both results emerge in order with no loss or duplicate, and issue resumes in the same cycle as the first pop.
- Exception passthrough: OP_ADD, reg1=0x7FFFFFFF, reg2=1 → cdb_ex.valid=1, exc_code=EXCCODE_OV, cdb_result=0x80000000.
- Flush mid-flight: with one op in the issue register and one in the FIFO (cdb_ready=0), pulse flush → next cycle cdb_valid=0 and no stale result ever appears. The next grant goes to the requester after the last grantee.
- Async reset: drive rst_n low between clock edges with occ=2 → cdb_valid and req_ready fall immediately. After release, rr_ptr=0, so requester 0 wins when req_valid=1111.
